// File: rtl/bp_resolve_unit.sv
// Branch-resolution consumer: trains a 2-bit PHT, keeps committed/speculative GHR, redirects fetch.
// Define BP_GSHARE_EN to index the PHT with PC XOR GHR (gshare); otherwise the index is PC only.
module bp_resolve_unit #(
  parameter int unsigned PHT_IDX_BITS = 10,
  parameter int unsigned GHR_BITS     = 10,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                bcond_resolved_in,
  input  logic                pc_incorrect_in,
  input  logic                taken_in,
  input  logic [63:0]         pc_in,
  input  logic [18:0]         correction_offset_in,
  input  logic                backend_ready_in,
  input  logic                pred_valid_in,
  input  logic [63:0]         pred_pc_in,
  output logic                pred_valid_out,
  output logic                pred_taken_out,
  output logic                redirect_valid_out,
  output logic [63:0]         redirect_pc_out,
  output logic                fetch_stall_out,
  output logic [GHR_BITS-1:0] ghr_out
);

  localparam int unsigned PhtEntries = 1 << PHT_IDX_BITS;

  typedef enum logic [1:0] {StInit, StIdle, StRedirect, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [PHT_IDX_BITS-1:0] init_cnt_q, init_cnt_d;
  logic [3:0]              drain_cnt_q, drain_cnt_d;
  logic [GHR_BITS-1:0]     commit_ghr_q, commit_ghr_d;
  logic [GHR_BITS-1:0]     spec_ghr_q, spec_ghr_d;
  logic                    train_valid_q, train_valid_d;
  logic                    train_taken_q, train_taken_d;
  logic [PHT_IDX_BITS-1:0] train_idx_q, train_idx_d;
  logic                    pred_valid_q, pred_valid_d;
  logic                    pred_taken_q, pred_taken_d;
  logic                    redirect_valid_q, redirect_valid_d;
  logic [63:0]             redirect_pc_q, redirect_pc_d;

  logic [1:0]              pht_q [PhtEntries];
  logic                    pht_we;
  logic [PHT_IDX_BITS-1:0] pht_waddr;
  logic [1:0]              pht_wdata;
  logic [1:0]              pht_train_cur;

  logic                    accept_res, mispredict, lookup;
  logic [PHT_IDX_BITS-1:0] res_idx, lookup_idx;
  logic [63:0]             br_off, target_pc;
  logic                    unused_pred_pc;

  function automatic logic [GHR_BITS-1:0] ghr_shift(input logic [GHR_BITS-1:0] ghr,
                                                    input logic b);
    logic [GHR_BITS:0] ext;
    ext = {ghr, b};
    return ext[GHR_BITS-1:0];
  endfunction

`ifdef BP_GSHARE_EN
  assign res_idx    = pc_in[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(commit_ghr_q);
  assign lookup_idx = pred_pc_in[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(spec_ghr_q);
`else
  assign res_idx    = pc_in[PHT_IDX_BITS+1:2];
  assign lookup_idx = pred_pc_in[PHT_IDX_BITS+1:2];
`endif

  assign unused_pred_pc = ^{pred_pc_in[63:PHT_IDX_BITS+2], pred_pc_in[1:0]};

  assign accept_res = bcond_resolved_in && (state_q != StInit);
  assign mispredict = accept_res && pc_incorrect_in;
  assign lookup     = pred_valid_in && backend_ready_in && (state_q == StIdle);

  assign br_off    = {{43{correction_offset_in[18]}}, correction_offset_in, 2'b00};
  assign target_pc = taken_in ? pc_in + br_off : pc_in + 64'd4;

  // The counter is read at write time, so a write from the previous edge is already
  // visible and back-to-back resolves to one index chain correctly.
  assign pht_train_cur = pht_q[train_idx_q];

  always_comb begin
    state_d          = state_q;
    init_cnt_d       = init_cnt_q;
    drain_cnt_d      = drain_cnt_q;
    pht_we           = 1'b0;
    pht_waddr        = train_idx_q;
    pht_wdata        = pht_train_cur;
    if (train_taken_q && pht_train_cur != 2'b11) pht_wdata = pht_train_cur + 2'b01;
    if (!train_taken_q && pht_train_cur != 2'b00) pht_wdata = pht_train_cur - 2'b01;

    unique case (state_q)
      StInit: begin
        pht_we     = 1'b1;
        pht_waddr  = init_cnt_q;
        pht_wdata  = 2'b01;
        init_cnt_d = init_cnt_q + 1'b1;
        if (&init_cnt_q) state_d = StIdle;
      end
      StIdle: pht_we = train_valid_q;
      StRedirect: begin
        pht_we      = train_valid_q;
        state_d     = StDrain;
        drain_cnt_d = 4'(FLUSH_CYCLES - 1);
      end
      StDrain: begin
        pht_we = train_valid_q;
        if (drain_cnt_q == '0) state_d = StIdle;
        else drain_cnt_d = drain_cnt_q - 1'b1;
      end
      default: state_d = StInit;
    endcase
    if (mispredict) state_d = StRedirect;

    train_valid_d = accept_res;
    train_idx_d   = res_idx;
    train_taken_d = taken_in;
    commit_ghr_d  = accept_res ? ghr_shift(commit_ghr_q, taken_in) : commit_ghr_q;

    // Restore from committed history wins over a same-cycle lookup shift.
    spec_ghr_d = spec_ghr_q;
    if (pred_valid_q) spec_ghr_d = ghr_shift(spec_ghr_q, pred_taken_q);
    if (mispredict) spec_ghr_d = ghr_shift(commit_ghr_q, taken_in);

    pred_valid_d     = lookup && !mispredict;
    pred_taken_d     = pred_valid_d && pht_q[lookup_idx][1];
    redirect_valid_d = mispredict;
    redirect_pc_d    = mispredict ? target_pc : redirect_pc_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q          <= StInit;
      init_cnt_q       <= '0;
      drain_cnt_q      <= '0;
      commit_ghr_q     <= '0;
      spec_ghr_q       <= '0;
      train_valid_q    <= 1'b0;
      train_taken_q    <= 1'b0;
      train_idx_q      <= '0;
      pred_valid_q     <= 1'b0;
      pred_taken_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      init_cnt_q       <= init_cnt_d;
      drain_cnt_q      <= drain_cnt_d;
      commit_ghr_q     <= commit_ghr_d;
      spec_ghr_q       <= spec_ghr_d;
      train_valid_q    <= train_valid_d;
      train_taken_q    <= train_taken_d;
      train_idx_q      <= train_idx_d;
      pred_valid_q     <= pred_valid_d;
      pred_taken_q     <= pred_taken_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // Table contents are established by the INIT sweep rather than by reset.
  always_ff @(posedge clk_in) begin
    if (pht_we) pht_q[pht_waddr] <= pht_wdata;
  end

  assign pred_valid_out     = pred_valid_q;
  assign pred_taken_out     = pred_taken_q;
  assign redirect_valid_out = redirect_valid_q;
  assign redirect_pc_out    = redirect_pc_q;
  assign fetch_stall_out    = (state_q != StIdle) || !backend_ready_in;
  assign ghr_out            = spec_ghr_q;

endmodule

// File: doc/bp_resolve_unit.md
# bp_resolve_unit

Front-end consumer of the backend's branch-resolution interface. Samples resolved conditional branches, trains a 2-bit saturating pattern history table (PHT), and maintains committed and speculative global history registers (GHR). Generates the fetch redirect PC on a misprediction and holds fetch off while the front end drains. Answers per-cycle direction lookups from fetch with 1-cycle latency.

## Interface
- PHT_IDX_BITS, 10, PHT index width; the table holds 2^PHT_IDX_BITS 2-bit counters
- GHR_BITS, 10, history length; legal range 1..PHT_IDX_BITS
- FLUSH_CYCLES, 2, cycles fetch stays stalled after the redirect pulse; legal range 1..15

Ports:
- clk_in  in  1  single clock; all state changes on the rising edge
- rst_in  in  1  synchronous, active-high reset
- bcond_resolved_in  in  1  a conditional branch resolved this cycle; at most one per cycle, in program order
- pc_incorrect_in  in  1  the front-end prediction for this branch was wrong
- taken_in  in  1  resolved direction
- pc_in  in  64  PC of the resolved branch
- correction_offset_in  in  19  signed word offset of the branch target
- backend_ready_in  in  1  backend can accept instructions
- pred_valid_in  in  1  fetch requests a direction prediction
- pred_pc_in  in  64  PC of the branch to predict
- pred_valid_out  out  1  prediction result valid
- pred_taken_out  out  1  predicted direction (counter MSB)
- redirect_valid_out  out  1  one-cycle pulse: fetch must restart at redirect_pc_out
- redirect_pc_out  out  64  corrected fetch PC
- fetch_stall_out  out  1  fetch must not issue
- ghr_out  out  GHR_BITS  speculative GHR

## Operation
- State machine: INIT, IDLE, REDIRECT, DRAIN. Reset enters INIT.
- INIT:
  - A sweep counter writes 2'b01 (weakly not-taken) to each PHT entry, one entry per cycle, 2^PHT_IDX_BITS cycles, then moves to IDLE.
  - Resolves and lookups arriving in INIT are dropped.
- PHT index: pc[PHT_IDX_BITS+1:2] XOR zero-extended GHR. Lookups use the speculative GHR; training uses the committed GHR.
- Training: an accepted resolve is registered, then its counter is written on the next edge.
  - Taken increments the counter, saturating at 3; not-taken decrements it, saturating at 0.
  - Back-to-back resolves to the same index forward the pending value, so no update is lost.
- Committed GHR on every accepted resolve: commit_ghr <= {commit_ghr[GHR_BITS-2:0], taken_in}.
- Speculative GHR:
  - On each lookup result: shift in pred_taken_out.
  - On a mispredict: set to {commit_ghr[GHR_BITS-2:0], taken_in}. This overrides any same-cycle lookup shift.
- Mispredict (bcond_resolved_in && pc_incorrect_in) in IDLE, REDIRECT or DRAIN moves to REDIRECT.
  - redirect_pc_out = taken_in ? pc_in + (sext(correction_offset_in) << 2) : pc_in + 4, in 64-bit modulo arithmetic.
  - A newer mispredict during REDIRECT or DRAIN restarts REDIRECT with the new PC.
- REDIRECT lasts 1 cycle, then DRAIN. DRAIN counts FLUSH_CYCLES cycles, then returns to IDLE.
- Lookups are accepted only in IDLE with backend_ready_in high. A lookup result that is due in the cycle a mispredict is taken is suppressed.
- fetch_stall_out = (state != IDLE) || !backend_ready_in.

## Timing
- Reset values: pred_valid_out=0, pred_taken_out=0, redirect_valid_out=0, redirect_pc_out=0, fetch_stall_out=1, ghr_out=0; committed GHR = 0.
- Lookup latency: pred_valid_in sampled at edge N gives pred_valid_out and pred_taken_out in cycle N+1, valid for one cycle.
- A PHT write at edge N is not visible to a lookup sampled at edge N; that lookup reads the pre-write value.
- Mispredict sampled at edge N:
  - redirect_valid_out is high for cycle N+1 only.
  - fetch_stall_out is high for cycles N+1 through N+1+FLUSH_CYCLES.
- rst_in asserted mid-REDIRECT or mid-DRAIN aborts immediately; the unit re-enters INIT and redirect_valid_out drops on the next cycle.

## Configuration
- BP_GSHARE_EN defined: index = PC bits XOR GHR (gshare).
- BP_GSHARE_EN undefined: index = pc[PHT_IDX_BITS+1:2] only (bimodal). GHR update, restore and ghr_out behave identically in both builds.

## Test plan
- Reset, wait 1024 cycles, then lookup PC 0x1000 -> fetch_stall_out high throughout INIT; pred_valid_out=1 with pred_taken_out=0 one cycle after the lookup.
- Two taken resolves of PC 0x1000 on consecutive cycles with GHR 0, BP_GSHARE_EN undefined -> counter reaches 3; a subsequent lookup returns taken.
- Mispredict: pc_in=0x2000, taken_in=1, offset=-4 -> redirect_valid_out pulse with redirect_pc_out=0x1FF0; fetch_stall_out high for 3 cycles.
- Not-taken mispredict at pc_in=0xFFFF_FFFF_FFFF_FFFC -> redirect_pc_out=0x0 (wrap).
- Second mispredict during DRAIN -> new redirect pulse with the new PC; DRAIN count restarts; speculative GHR equals {committed GHR, taken}.
- rst_in asserted in the REDIRECT cycle -> state returns to INIT; ghr_out=0; no further redirect pulse.
